// File: rtl/riscv_fetch.sv
// riscv_fetch -- instruction fetch unit.
//
// Owns the program counter and fetches one 32-bit instruction word at a time
// from instruction memory. Each word is handed to decode together with its PC.
// Execute can redirect the PC at any time with a one-cycle pulse.
//
// Optional feature macro: RISCV_FETCH_ALIGN_CHECK_EN
//   defined   : a redirect to a non-word-aligned PC parks the unit in FAULT
//               and raises a sticky `fault` flag until reset.
//   undefined : redirect_pc[1:0] is ignored (forced to 00) and `fault` is 0.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both 1. The source holds the payload stable
// while valid is 1 and no transfer has happened. The single exception is a
// redirect while a request waits in REQ, which retargets req_addr.
// rsp_valid is a single-cycle strobe with no ready; exactly one response
// returns per accepted request.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   instruction memory request, req_addr = word address
//   rsp_valid/rsp_data    instruction memory response
//   inst_valid/inst_ready instruction to decode, inst + inst_pc
//   redirect/redirect_pc  PC replacement pulse from execute
//   fault                 sticky misaligned-redirect flag
//
// The internal `state` signal carries the FSM state (REQ/WAIT/HOLD/FAULT)
// for probing.
module riscv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        kill, kill_nxt;
  logic [31:0] inst_nxt, inst_pc_nxt;
  logic        req_valid_st;
  logic [31:0] redirect_tgt;
  logic        misaligned;

`ifdef RISCV_FETCH_ALIGN_CHECK_EN
  assign redirect_tgt = redirect_pc;
  assign misaligned   = redirect && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault <= 1'b0;
    end else if (misaligned) begin
      fault <= 1'b1;
    end
  end
`else
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign misaligned   = 1'b0;
  assign fault        = 1'b0;
`endif

  // REQ is the reset state, so the request must be masked while reset is
  // still asserted.
  assign req_valid = req_valid_st && !rst;
  assign req_addr  = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      kill    <= 1'b0;
      inst    <= 32'h0;
      inst_pc <= 32'h0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      kill    <= kill_nxt;
      inst    <= inst_nxt;
      inst_pc <= inst_pc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    kill_nxt     = kill;
    inst_nxt     = inst;
    inst_pc_nxt  = inst_pc;
    req_valid_st = 1'b0;
    inst_valid   = 1'b0;

    case (state)
      S_REQ: begin
        req_valid_st = 1'b1;
        if (req_ready) begin
          state_nxt = S_WAIT;
          // An accepted request that is already stale must have its
          // response thrown away when it returns.
          if (redirect) kill_nxt = 1'b1;
        end
        if (redirect) pc_nxt = redirect_tgt;
      end

      S_WAIT: begin
        if (rsp_valid) begin
          if (kill || redirect) begin
            kill_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else begin
            inst_nxt    = rsp_data;
            inst_pc_nxt = pc;
            pc_nxt      = pc + 32'd4;
            state_nxt   = S_HOLD;
          end
        end else if (redirect) begin
          kill_nxt = 1'b1;
        end
        if (redirect) pc_nxt = redirect_tgt;
      end

      S_HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready || redirect) state_nxt = S_REQ;
        if (redirect) pc_nxt = redirect_tgt;
      end

      S_FAULT: begin
        // Terminal until reset; late responses are simply ignored.
      end

      default: state_nxt = S_REQ;
    endcase

    if (misaligned) begin
      state_nxt = S_FAULT;
      pc_nxt    = pc;
    end
  end

endmodule

// File: tb/tb_riscv_fetch.sv
// Bench for riscv_fetch: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level model of the fetch stream,
// plus literal expectations for the directed scenarios. A second instance
// with RESET_PC = 32'hFFFF_FFFC covers PC wrap-around.
module tb_riscv_fetch;

  localparam logic [31:0] RPC1 = 32'h0000_0100;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 1 ----------------
  logic        req_valid, req_ready, rsp_valid, inst_valid, inst_ready;
  logic        redirect, fault;
  logic [31:0] req_addr, rsp_data, inst, inst_pc, redirect_pc;

  riscv_fetch #(.RESET_PC(RPC1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .fault(fault)
  );

  // ---------------- DUT 2 (wrap-around) ----------------
  logic        req_valid2, req_ready2, rsp_valid2, inst_valid2, inst_ready2;
  logic        redirect2, fault2;
  logic [31:0] req_addr2, rsp_data2, inst2, inst_pc2, redirect_pc2;

  riscv_fetch #(.RESET_PC(RPC2)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_addr(req_addr2),
    .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
    .inst_valid(inst_valid2), .inst_ready(inst_ready2),
    .inst(inst2), .inst_pc(inst_pc2),
    .redirect(redirect2), .redirect_pc(redirect_pc2), .fault(fault2)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model of the fetch stream: next address to request, the request in
  // flight (and whether a redirect has made it stale), the instruction
  // offered to decode, and the last instruction/PC handed over.
  bit          m_out, m_killed, m_hold, m_fault;
  logic [31:0] m_next, m_out_addr, m_inst, m_pc;

  logic [31:0] req_q[$];
  logic [31:0] got_q[$];
  logic [31:0] got_inst_q[$];
  int          got_cyc_q[$];
  logic [31:0] req2_q[$];
  logic [31:0] got2_q[$];
  bit          acc2;
  logic [31:0] addr2_last;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_killed = 0; m_hold = 0; m_fault = 0;
    m_next = RPC1; m_out_addr = 32'h0; m_inst = 32'h0; m_pc = 32'h0;
  endtask

  task automatic clear_logs();
    req_q.delete(); got_q.delete(); got_inst_q.delete(); got_cyc_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    req_ready = 0; rsp_valid = 0; rsp_data = 0; inst_ready = 0;
    redirect = 0; redirect_pc = 0;
    req_ready2 = 0; rsp_valid2 = 0; rsp_data2 = 0; inst_ready2 = 0;
    redirect2 = 0; redirect_pc2 = 0;
    acc2 = 0; addr2_last = 0;
    model_reset();
    repeat (n) begin
      @(negedge clk);
      cyc++;
      chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
      chk("rst_req_addr", req_addr, RPC1);
      chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_fault", {31'b0, fault}, 32'd0);
      chk("rst_req_addr2", req_addr2, RPC2);
    end
    rst = 1'b0;
  endtask

  // One clock cycle: check outputs against the model, drive inputs, then
  // advance the model by the events of the coming rising edge.
  task automatic step(input bit rr, input bit rv_want, input bit ir,
                      input bit rd, input logic [31:0] rpc);
    bit          exp_req, rv;
    logic [31:0] tgt;
    @(negedge clk);
    cyc++;
    exp_req = !m_out && !m_hold && !m_fault;
    chk("req_valid", {31'b0, req_valid}, {31'b0, exp_req});
    if (exp_req) chk("req_addr", req_addr, m_next);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_hold});
    chk("inst", inst, m_inst);
    chk("inst_pc", inst_pc, m_pc);
    chk("fault", {31'b0, fault}, {31'b0, m_fault});

    // memory only answers an outstanding request
    rv          = rv_want && m_out;
    req_ready   = rr;
    rsp_valid   = rv;
    rsp_data    = rv ? mem(m_out_addr) : $urandom;
    inst_ready  = ir;
    redirect    = rd;
    redirect_pc = rpc;

    if (req_valid && rr) req_q.push_back(req_addr);
    if (inst_valid && ir) begin
      got_q.push_back(inst_pc);
      got_inst_q.push_back(inst);
      got_cyc_q.push_back(cyc);
    end

    // second instance: zero-wait memory, decode always ready
    req_ready2  = 1'b1;
    inst_ready2 = 1'b1;
    rsp_valid2  = acc2;
    rsp_data2   = mem(addr2_last);
    if (inst_valid2) got2_q.push_back(inst_pc2);
    if (req_valid2) req2_q.push_back(req_addr2);
    acc2       = req_valid2;
    addr2_last = req_addr2;

    // model update
    tgt = ALIGN ? rpc : {rpc[31:2], 2'b00};
    if (m_fault) begin
      if (rv) m_out = 0;
    end else if (ALIGN && rd && (rpc[1:0] != 2'b00)) begin
      m_fault = 1;
      m_hold  = 0;
      if (exp_req && rr) m_out = 1;
      else if (rv) m_out = 0;
    end else if (m_hold) begin
      if (rd || ir) m_hold = 0;
      if (rd) m_next = tgt;
    end else if (!m_out) begin
      if (rr) begin
        m_out      = 1;
        m_out_addr = m_next;
        m_killed   = rd;
      end
      if (rd) m_next = tgt;
    end else begin
      if (rv) begin
        m_out = 0;
        if (!m_killed && !rd) begin
          m_hold = 1;
          m_pc   = m_out_addr;
          m_inst = mem(m_out_addr);
          m_next = m_out_addr + 32'd4;
        end
      end else if (rd) begin
        m_killed = 1;
      end
      if (rd) m_next = tgt;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    do_reset(2);

    // zero-wait memory, decode always ready
    clear_logs();
    repeat (9) step(1, 1, 1, 0, 32'h0);
    chk("zw_count", got_q.size(), 32'd3);
    chk("zw_pc0", got_q[0], 32'h0000_0100);
    chk("zw_pc1", got_q[1], 32'h0000_0104);
    chk("zw_pc2", got_q[2], 32'h0000_0108);
    chk("zw_inst0", got_inst_q[0], 32'hA5A5_0100);
    chk("zw_period", got_cyc_q[1] - got_cyc_q[0], 32'd3);
    chk("zw_first_cycle", got_cyc_q[0], 32'd5);
    chk("wrap_req0", req2_q[0], 32'hFFFF_FFFC);
    chk("wrap_req1", req2_q[1], 32'h0000_0000);
    chk("wrap_inst_pc", got2_q[0], 32'hFFFF_FFFC);

    // decode stalls for 5 cycles
    clear_logs();
    step(1, 1, 1, 0, 32'h0);
    step(1, 1, 1, 0, 32'h0);
    repeat (5) step(1, 1, 0, 0, 32'h0);
    step(1, 1, 1, 0, 32'h0);
    chk("stall_req_count", req_q.size(), 32'd1);
    chk("stall_got_pc", got_q[0], 32'h0000_010C);
    chk("stall_got_count", got_q.size(), 32'd1);
    step(1, 0, 1, 0, 32'h0);
    chk("stall_next_req", req_q[1], 32'h0000_0110);

    // redirect while waiting for the response
    clear_logs();
    req_q.push_back(32'h0000_0110);
    step(1, 0, 1, 1, 32'h0000_2000);
    step(1, 1, 1, 0, 32'h0);
    step(1, 0, 1, 0, 32'h0);
    step(1, 1, 1, 0, 32'h0);
    step(1, 0, 1, 0, 32'h0);
    chk("wait_redir_req", req_q[1], 32'h0000_2000);
    chk("wait_redir_got_n", got_q.size(), 32'd1);
    chk("wait_redir_got", got_q[0], 32'h0000_2000);

    // redirect with acceptance, then redirect with the response
    clear_logs();
    step(1, 0, 1, 1, 32'h0000_3000);
    step(1, 1, 1, 1, 32'h0000_4000);
    step(1, 0, 1, 0, 32'h0);
    step(1, 1, 1, 0, 32'h0);
    step(1, 0, 1, 0, 32'h0);
    chk("dbl_req0", req_q[0], 32'h0000_2004);
    chk("dbl_req1", req_q[1], 32'h0000_4000);
    chk("dbl_got_n", got_q.size(), 32'd1);
    chk("dbl_got", got_q[0], 32'h0000_4000);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r;
      r = $urandom;
      if (ALIGN) r[1:0] = 2'b00;
      step($urandom_range(0, 1), $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) == 0, r);
    end

    // reset in the middle of a fetch
    for (int i = 0; i < 20 && !m_out; i++) step(1, 0, 1, 0, 32'h0);
    chk("midrst_outstanding", {31'b0, m_out}, 32'd1);
    do_reset(2);
    clear_logs();
    repeat (3) step(1, 1, 1, 0, 32'h0);
    chk("midrst_req", req_q[0], 32'h0000_0100);
    chk("midrst_got", got_q[0], 32'h0000_0100);

    // misaligned redirect
    clear_logs();
    step(0, 0, 1, 1, 32'h0000_2002);
    repeat (6) step(1, 1, 1, 0, 32'h0);
    if (ALIGN) begin
      chk("mis_req_count", req_q.size(), 32'd0);
      chk("mis_fault", {31'b0, fault}, 32'd1);
    end else begin
      chk("mis_req", req_q[0], 32'h0000_2000);
      chk("mis_fault", {31'b0, fault}, 32'd0);
      chk("mis_got", got_q[0], 32'h0000_2000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_fetch.md
# riscv_fetch

Instruction fetch unit supplying the 32-bit `inst` word that the core datapath consumes. It owns the program counter and issues word reads to instruction memory over a valid/ready request channel with a separate response channel. It presents each fetched word, with its PC, to decode through a valid/ready handshake and accepts redirects (branch/jump targets) from execute. One request is outstanding at a time.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC of the first fetch after reset.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  out  1  fetch request to instruction memory.
- `req_ready`  in  1  memory accepts the request.
- `req_addr`  out  32  word address, bits [1:0] always 0.
- `rsp_valid`  in  1  read data valid; memory returns exactly one response per accepted request.
- `rsp_data`  in  32  instruction word.
- `inst_valid`  out  1  `inst` and `inst_pc` are valid for decode.
- `inst_ready`  in  1  decode consumes the instruction.
- `inst`  out  32  fetched instruction.
- `inst_pc`  out  32  PC of `inst`.
- `redirect`  in  1  one-cycle pulse that replaces the PC.
- `redirect_pc`  in  32  new PC, sampled when `redirect`=1.
- `fault`  out  1  misaligned redirect flag (see Configuration).

## Operation
- State register `pc` (32 b), `kill` flag, FSM states REQ, WAIT, HOLD, FAULT.
- Reset: state=REQ, `pc`=RESET_PC, `kill`=0. Outputs: `req_valid`=0 while `rst`=1, `req_addr`=RESET_PC, `inst_valid`=0, `inst`=0, `inst_pc`=0, `fault`=0.
- REQ: `req_valid`=1, `req_addr`=`pc`.
  - `req_ready`=1 and no redirect → WAIT.
  - `req_ready`=1 and `redirect` → WAIT, `kill`←1, `pc`←`redirect_pc`. The handshake stands.
  - `req_ready`=0 and `redirect` → stay REQ, `pc`←`redirect_pc`. `req_addr` changes without a handshake; this is the only permitted change of an unaccepted request.
- WAIT: `req_valid`=0.
  - `rsp_valid` with `kill`=1 → discard the data, `kill`←0, go to REQ.
  - `rsp_valid` with `kill`=0 → `inst`←`rsp_data`, `inst_pc`←`pc`, `pc`←`pc`+4, go to HOLD.
  - `redirect` → `kill`←1, `pc`←`redirect_pc`. If `rsp_valid` arrives in the same cycle, the response is discarded, `kill`←0, and the FSM goes to REQ.
- HOLD: `inst_valid`=1. `inst` and `inst_pc` stay stable until handshake or redirect.
  - `inst_ready` → REQ.
  - `redirect` without `inst_ready` → instruction dropped, `pc`←`redirect_pc`, go to REQ.
  - `redirect` with `inst_ready` → instruction counts as consumed, `pc`←`redirect_pc`, go to REQ.
- `pc`+4 wraps modulo 2^32: 32'hFFFF_FFFC → 32'h0000_0000.
- `inst` and `inst_pc` retain their last values outside HOLD.
- `redirect` takes priority over sequential PC increment in every state.

## Timing
- First `req_valid`=1 is in the first cycle after `rst` deasserts.
- With zero-wait memory (`req_ready`=1, `rsp_valid` exactly one cycle after acceptance) and `inst_ready` held at 1, the sequence is: request cycle N, response N+1, `inst_valid` N+2, next request N+3. Throughput is 1 instruction per 3 cycles.
- Redirect to new request: a redirect seen in cycle N puts `req_addr`=`redirect_pc` in cycle N+1 (REQ/HOLD), or in the cycle after the pending response returns (WAIT).
- Asserting `rst` mid-operation immediately clears all state. The memory's pending response belongs to the environment; the bench resets memory together with this block.

## Configuration
- `RISCV_FETCH_ALIGN_CHECK_EN` defined:
  - `redirect` with `redirect_pc[1:0]`≠0 → FSM enters FAULT and `fault`←1 (sticky).
  - In FAULT, `req_valid`=0 and `inst_valid`=0 until reset. Any outstanding response is absorbed and ignored.
- Not defined:
  - `fault` is tied to 0.
  - `redirect_pc[1:0]` is ignored; the PC is loaded with bits [1:0] forced to 00. FAULT is unreachable.

## Test plan
- Reset with RESET_PC=32'h0000_0100, zero-wait memory returning addr^32'hA5A5_0000 → `inst_pc` sequence 100, 104, 108; `inst`=32'hA5A5_0100, …; `inst_valid` every 3rd cycle.
- Hold `inst_ready`=0 for 5 cycles in HOLD → `inst` and `inst_pc` stable, no new `req_valid`; release → next request addr 32'h0000_0104.
- `redirect` to 32'h0000_2000 during WAIT → the returning response is dropped (no `inst_valid`), next `req_addr`=32'h2000, then `inst_pc`=32'h2000.
- `redirect` together with `req_ready` in REQ, then `redirect` together with `rsp_valid` in WAIT → exactly one accepted request, no `inst_valid`, then a request to the second target.
- RESET_PC=32'hFFFF_FFFC → second request addr 32'h0000_0000.
- With macro: `redirect_pc`=32'h0000_2002 → `fault`=1 next cycle, no further `req_valid`; without macro → `req_addr`=32'h0000_2000, `fault`=0.
